reg_share_arbiter: RTL and testbench
====================================

// Module: reg_share_arbiter
//
// PURPOSE
// Round-robin arbiter sharing one NBITS-wide D flip-flop register among NREQ
// requesters. Each granted request writes its data into the register at the
// next rising edge. After each write the arbiter stays busy for HOLD settle
// cycles before it grants again. Sits between multiple producers and a
// single shared state register, for example a shared config or status flop.
//
// PARAMETERS
// NREQ   4  number of requesters (>=2)
// NBITS  8  width of shared register and each requester's data
// HOLD   2  idle cycles enforced after each write (0 = back-to-back writes)
//
// PORTS
// clk        in   1           clock, all state updates on rising edge
// reset      in   1           asynchronous, active-high reset
// req        in   NREQ        per-requester write request; level, held until granted
// req_data   in   NREQ*NBITS  requester i's data in bits [i*NBITS +: NBITS]
// grant      out  NREQ        one-hot write acknowledge (combinational); the write happens at this edge
// q          out  NBITS       shared register contents
// q_owner    out  $clog2(NREQ) index of the requester that last wrote q
// busy       out  1           high while in HOLD state
//
// BEHAVIOUR
// - Clock and reset: one clock, clk. reset is asynchronous and active-high.
//   While reset=1: q=0, q_owner=0, rr pointer ptr=0, state=IDLE, hold counter=0,
//   busy=0, grant=0.
// - States:
//   - IDLE: grant is allowed.
//   - HOLD: grant is forced to 0; the hold counter counts down.
// - IDLE with req!=0:
//   - The winner is the first i with req[i]=1, scanning ptr, ptr+1, ... and
//     wrapping modulo NREQ.
//   - grant[winner]=1 in the same cycle.
//   - At the rising edge: q<=req_data[winner], q_owner<=winner, ptr<=(winner+1)%NREQ.
//   - If HOLD>0: state<=HOLD and counter<=HOLD-1. If HOLD==0: stay in IDLE.
// - IDLE with req==0: grant=0. q, q_owner and ptr hold their values.
// - HOLD:
//   - busy=1 and grant=0. Requests are ignored but stay pending at the requester.
//   - If counter==0: state<=IDLE. Otherwise counter<=counter-1.
//   - HOLD lasts exactly HOLD cycles.
// - Latency: a request arriving in IDLE is granted in the same cycle, and q
//   updates one edge later. Worst-case wait is (NREQ-1)*(HOLD+1) cycles.
// - Fairness: a requester that just won has the lowest priority in the next
//   arbitration. ptr moves only on a grant.
// - Width: ptr, q_owner and winner are $clog2(NREQ) bits. Wrap from NREQ-1 to 0
//   is explicit, so non-power-of-2 NREQ is correct.
// - grant is never multi-hot and never asserted in HOLD or during reset.
// - Reset mid-HOLD or mid-grant cancels the write and returns to IDLE with
//   ptr=0 and q=0 immediately.
// - A requester dropping req in the same cycle it is granted is legal; the
//   write still occurs at that edge.
//
// TESTING
// 1. Reset: assert reset between edges -> q=0, q_owner=0, grant=0, busy=0
//    without waiting for a clock edge.
// 2. Single requester, NREQ=4, HOLD=2: req=4'b0100, data[2]=8'hA5 ->
//    grant=4'b0100 in cycle 0; q=8'hA5 and q_owner=2 after the edge;
//    busy=1 for 2 cycles; grant re-asserts in cycle 3.
// 3. All requesting, req=4'b1111 held, HOLD=0 -> grants go 0,1,2,3,0 on
//    consecutive cycles, and q follows each requester's data one cycle later.
// 4. Round-robin skip: ptr=1 (after granting 0), req=4'b1001 -> grant=4'b1000,
//    then ptr=0 and the next grant is 4'b0001.
// 5. Non-power-of-2: NREQ=3, req=3'b111, HOLD=1 -> grant sequence 0,-,1,-,2,-,0
//    with busy high on the '-' cycles; q_owner wraps from 2 to 0.
// 6. Reset mid-HOLD: write 8'h3C, assert reset during the first HOLD cycle ->
//    q=0, busy=0, state IDLE; after release with req=4'b1000 -> grant goes to 3.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// ============================================================================
// Module   : reg_share_arbiter
// Brief    : Round-robin arbiter sharing one NBITS-wide register among NREQ
//            requesters, with a HOLD-cycle settle window after each write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*NBITS-1:0]     req_data,
  output logic [NREQ-1:0]           grant,
  output logic [NBITS-1:0]          q,
  output logic [$clog2(NREQ)-1:0]   q_owner,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [NBITS-1:0] data_q, data_d;

  logic [NREQ-1:0]  w_mask;
  logic [NREQ-1:0]  w_req_hi;
  logic [NREQ-1:0]  w_pick;
  logic [NREQ-1:0]  w_onehot;
  logic [PW-1:0]    w_winner;
  logic [NBITS-1:0] w_wdata;
  logic             w_grant_ok;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_mask
      assign w_mask[i] = (PW'(i) >= ptr_q);
    end
  endgenerate

  assign w_req_hi = req & w_mask;
  assign w_pick   = (|w_req_hi) ? w_req_hi : req;
  assign w_onehot = w_pick & (~w_pick + NREQ'(1));

  always_comb begin
    w_winner = '0;
    w_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_onehot[i]) begin
        w_winner = PW'(i);
        w_wdata  = req_data[i*NBITS +: NBITS];
      end
    end
  end

  assign w_grant_ok = (state_q == ST_IDLE) && !reset;
  assign grant      = w_grant_ok ? w_onehot : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          data_d  = w_wdata;
          owner_d = w_winner;
          ptr_d   = (w_winner == PW'(NREQ-1)) ? '0 : w_winner + PW'(1);
          if (HOLD > 0) begin
            state_d = ST_HOLD;
            cnt_d   = CW'(HOLD-1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
    end
  end

  assign q       = data_q;
  assign q_owner = owner_q;
  assign busy    = (state_q == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
// ============================================================================
// Module   : tb_reg_share_arbiter
// Brief    : Directed self-checking bench for reg_share_arbiter, exercising
//            HOLD=2, HOLD=0 and a non-power-of-2 NREQ=3 configuration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_share_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: NREQ=4, HOLD=2
  logic [3:0]  req_a, grant_a;
  logic [31:0] data_a;
  logic [7:0]  q_a;
  logic [1:0]  own_a;
  logic        busy_a;

  // Instance B: NREQ=4, HOLD=0
  logic [3:0]  req_b, grant_b;
  logic [31:0] data_b;
  logic [7:0]  q_b;
  logic [1:0]  own_b;
  logic        busy_b;

  // Instance C: NREQ=3, HOLD=1
  logic [2:0]  req_c, grant_c;
  logic [23:0] data_c;
  logic [7:0]  q_c;
  logic [1:0]  own_c;
  logic        busy_c;

  reg_share_arbiter #(.NREQ(4), .NBITS(8), .HOLD(2)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .req_data(data_a),
    .grant(grant_a), .q(q_a), .q_owner(own_a), .busy(busy_a)
  );

  reg_share_arbiter #(.NREQ(4), .NBITS(8), .HOLD(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .req_data(data_b),
    .grant(grant_b), .q(q_b), .q_owner(own_b), .busy(busy_b)
  );

  reg_share_arbiter #(.NREQ(3), .NBITS(8), .HOLD(1)) u_c (
    .clk(clk), .reset(reset), .req(req_c), .req_data(data_c),
    .grant(grant_c), .q(q_c), .q_owner(own_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    req_a  = 4'b1111;
    req_b  = 4'b0000;
    req_c  = 3'b000;
    data_a = 32'h0;
    data_b = 32'h0;
    data_c = 24'h0;

    // Reset state, with requests pending, before any clock edge
    #3;
    chk("rst_q",     32'(q_a),     32'h0);
    chk("rst_owner", 32'(own_a),   32'h0);
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    req_a = 4'b0000;
    reset = 1'b0;
    next();

    // Single requester, HOLD=2
    data_a = 32'h44A52211;
    req_a  = 4'b0100;
    #1;
    chk("single_grant0", 32'(grant_a), 32'h4);
    chk("single_busy0",  32'(busy_a),  32'h0);
    next();
    chk("single_q",      32'(q_a),     32'hA5);
    chk("single_owner",  32'(own_a),   32'h2);
    chk("single_busy1",  32'(busy_a),  32'h1);
    chk("single_gnt1",   32'(grant_a), 32'h0);
    next();
    chk("single_busy2",  32'(busy_a),  32'h1);
    chk("single_gnt2",   32'(grant_a), 32'h0);
    next();
    chk("single_busy3",  32'(busy_a),  32'h0);
    chk("single_gnt3",   32'(grant_a), 32'h4);
    next();
    req_a = 4'b0000;
    next();
    next();

    // Round-robin skip: ptr=3 -> grant 0 -> ptr=1 -> req 1001 picks 3, then 0
    data_a = 32'hD4C3B2A1;
    req_a  = 4'b0001;
    #1;
    chk("rr_grant0",  32'(grant_a), 32'h1);
    next();
    chk("rr_q0",      32'(q_a),     32'hA1);
    req_a = 4'b1001;
    next();
    next();
    chk("rr_grant3",  32'(grant_a), 32'h8);
    next();
    chk("rr_q3",      32'(q_a),     32'hD4);
    chk("rr_owner3",  32'(own_a),   32'h3);
    next();
    next();
    chk("rr_grant0b", 32'(grant_a), 32'h1);
    next();
    chk("rr_owner0b", 32'(own_a),   32'h0);
    req_a = 4'b0000;
    next();
    next();

    // All requesting with HOLD=0: grants 0,1,2,3,0 back to back
    data_b = 32'h8C7B6A59;
    req_b  = 4'b1111;
    #1;
    begin
      logic [31:0] exp_q;
      int idx;
      for (int k = 0; k < 5; k++) begin
        idx = k % 4;
        exp_q = (data_b >> (idx * 8)) & 32'hFF;
        chk("b2b_grant", 32'(grant_b), 32'(1) << idx);
        chk("b2b_busy",  32'(busy_b),  32'h0);
        next();
        chk("b2b_q",     32'(q_b),     exp_q);
        chk("b2b_owner", 32'(own_b),   32'(idx));
      end
    end
    req_b = 4'b0000;

    // Non-power-of-2 NREQ=3, HOLD=1: grants 0,-,1,-,2,-,0
    data_c = 24'hC2B1A0;
    req_c  = 3'b111;
    #1;
    begin
      logic [31:0] exp_q;
      int idx;
      for (int k = 0; k < 4; k++) begin
        idx = k % 3;
        exp_q = (32'(data_c) >> (idx * 8)) & 32'hFF;
        chk("np2_grant",  32'(grant_c), 32'(1) << idx);
        chk("np2_busy0",  32'(busy_c),  32'h0);
        next();
        chk("np2_busy1",  32'(busy_c),  32'h1);
        chk("np2_gnt_hold", 32'(grant_c), 32'h0);
        chk("np2_q",      32'(q_c),     exp_q);
        chk("np2_owner",  32'(own_c),   32'(idx));
        next();
      end
    end
    req_c = 3'b000;

    // Reset during the first HOLD cycle cancels state and clears the pointer
    data_a = 32'h7766553C;
    req_a  = 4'b0001;
    #1;
    chk("mid_grant0", 32'(grant_a), 32'h1);
    next();
    chk("mid_q",      32'(q_a),     32'h3C);
    chk("mid_busy",   32'(busy_a),  32'h1);
    req_a = 4'b1000;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_q",     32'(q_a),     32'h0);
    chk("mid_rst_busy",  32'(busy_a),  32'h0);
    chk("mid_rst_grant", 32'(grant_a), 32'h0);
    chk("mid_rst_owner", 32'(own_a),   32'h0);
    reset = 1'b0;
    #1;
    chk("mid_grant3",  32'(grant_a), 32'h8);
    next();
    chk("mid_q3",      32'(q_a),     32'h77);
    chk("mid_owner3",  32'(own_a),   32'h3);
    req_a = 4'b0000;
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
